// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (port 0 = ALU, port 1 = load)
// with a busy scoreboard of issued-but-unwritten destinations for decode RAW stalls.
module regs_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_req,
    input  logic [ADDR_W-1:0] wb_addr0,
    input  logic [DATA_W-1:0] wb_data0,
    input  logic [ADDR_W-1:0] wb_addr1,
    input  logic [DATA_W-1:0] wb_data1,
    output logic [1:0]        wb_ack,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              stall,
    output logic              L_S,
    output logic [ADDR_W-1:0] Wt_addr,
    output logic [DATA_W-1:0] Wt_data
);
    localparam int NREG = 2 ** ADDR_W;

    logic              last;       // port granted most recently; 1 gives port 0 the next tie
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              granted;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        wb_ack = 2'b00;
        if (!rst) begin
            case (wb_req)
                2'b01:   wb_ack = 2'b01;
                2'b10:   wb_ack = 2'b10;
                2'b11:   wb_ack = last ? 2'b01 : 2'b10;
                default: wb_ack = 2'b00;
            endcase
        end
    end

    always_comb begin
        granted = |wb_ack;
        g_addr  = wb_ack[1] ? wb_addr1 : wb_addr0;
        g_data  = wb_ack[1] ? wb_data1 : wb_data0;
    end

    // Clear on writeback first, then set on issue, so a same-cycle re-issue stays busy.
    always_comb begin
        busy_next = busy;
        if (granted && g_addr != '0)
            busy_next[g_addr] = 1'b0;
        if (iss_valid && iss_addr != '0)
            busy_next[iss_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign stall = busy[q_addr_a] | busy[q_addr_b];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            L_S     <= 1'b0;
            Wt_addr <= '0;
            Wt_data <= '0;
            busy    <= '0;
            last    <= 1'b1;
        end else begin
            busy <= busy_next;
            if (granted) begin
                last    <= wb_ack[1];
                L_S     <= (g_addr != '0);
                Wt_addr <= g_addr;
                Wt_data <= g_data;
            end else begin
                L_S <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed scenarios followed by randomized
// handshaking traffic compared against a behavioural register/scoreboard model.
module tb_regs_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        wb_req;
    logic [ADDR_W-1:0] wb_addr0;
    logic [DATA_W-1:0] wb_data0;
    logic [ADDR_W-1:0] wb_addr1;
    logic [DATA_W-1:0] wb_data1;
    logic [1:0]        wb_ack;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] q_addr_a;
    logic [ADDR_W-1:0] q_addr_b;
    logic              stall;
    logic              L_S;
    logic [ADDR_W-1:0] Wt_addr;
    logic [DATA_W-1:0] Wt_data;

    always #50 clk = ~clk;

    regs_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req),
        .wb_addr0(wb_addr0), .wb_data0(wb_data0),
        .wb_addr1(wb_addr1), .wb_data1(wb_data1),
        .wb_ack(wb_ack),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .stall(stall),
        .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: register-file port contents, set of outstanding destinations,
    // and which port won most recently.
    bit          m_busy[NREG];
    int          m_last;
    logic        m_ls;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [1:0]  last_ack;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last  = 1;
        m_ls    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Called just after a posedge with inputs already driven; checks, then advances one cycle.
    task automatic step();
        logic [1:0]  e_ack;
        logic        e_stall;
        logic [4:0]  a;
        logic [31:0] d;
        #1;
        e_ack = 2'b00;
        if (!rst) begin
            if (wb_req == 2'b11) e_ack = (m_last == 0) ? 2'b10 : 2'b01;
            else                 e_ack = wb_req;
        end
        e_stall = m_busy[q_addr_a] | m_busy[q_addr_b];
        check("ack",   {30'd0, wb_ack}, {30'd0, e_ack});
        check("stall", {31'd0, stall},  {31'd0, e_stall});
        check("ls",    {31'd0, L_S},    {31'd0, m_ls});
        check("waddr", {27'd0, Wt_addr}, {27'd0, m_waddr});
        check("wdata", Wt_data, m_wdata);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_ack != 2'b00) begin
                a = e_ack[1] ? wb_addr1 : wb_addr0;
                d = e_ack[1] ? wb_data1 : wb_data0;
                m_last  = e_ack[1] ? 1 : 0;
                m_ls    = (a != 0);
                m_waddr = a;
                m_wdata = d;
                if (a != 0) m_busy[a] = 1'b0;
            end else begin
                m_ls = 1'b0;
            end
            if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        last_ack = e_ack;
        #1;
    endtask

    bit          pend[2];
    logic [4:0]  r_addr[2];
    logic [31:0] r_data[2];
    logic [1:0]  t3_ack[4];

    initial begin
        rst = 1'b1; wb_req = 2'b11; iss_valid = 1'b1; iss_addr = 5'd3;
        wb_addr0 = 5'd3; wb_data0 = 32'h11; wb_addr1 = 5'd4; wb_data1 = 32'h22;
        q_addr_a = 5'd3; q_addr_b = 5'd4;
        last_ack = 2'b00;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with requests and an issue pending: nothing acked, nothing busy.
        check("t1_ack", {30'd0, wb_ack}, 32'd0);
        step();
        for (int r = 0; r < NREG; r++) begin
            q_addr_a = 5'(r);
            q_addr_b = 5'(NREG - 1 - r);
            #1;
            check("t1_busy", {31'd0, stall}, 32'd0);
        end
        step();
        rst = 1'b0; wb_req = 2'b00; iss_valid = 1'b0;
        q_addr_a = 5'd0; q_addr_b = 5'd0;
        step();

        // Lone port 1 request.
        wb_req = 2'b10; wb_addr1 = 5'd5; wb_data1 = 32'hDEADBEEF;
        #1;
        check("t2_ack", {30'd0, wb_ack}, 32'd2);
        step();
        wb_req = 2'b00;
        check("t2_ls",    {31'd0, L_S}, 32'd1);
        check("t2_waddr", {27'd0, Wt_addr}, 32'd5);
        check("t2_wdata", Wt_data, 32'hDEADBEEF);
        step();

        // Round-robin after reset with both ports contending.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb_req = 2'b11; wb_addr0 = 5'd3; wb_data0 = 32'hA3; wb_addr1 = 5'd4; wb_data1 = 32'hB4;
        t3_ack[0] = 2'b01; t3_ack[1] = 2'b10; t3_ack[2] = 2'b01; t3_ack[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_ack", {30'd0, wb_ack}, {30'd0, t3_ack[i]});
            step();
            check("t3_ls",    {31'd0, L_S}, 32'd1);
            check("t3_waddr", {27'd0, Wt_addr}, (i % 2 == 1) ? 32'd4 : 32'd3);
        end
        wb_req = 2'b00;
        step();

        // Issue r7, stall until the writeback edge.
        iss_valid = 1'b1; iss_addr = 5'd7; q_addr_a = 5'd7; q_addr_b = 5'd0;
        step();
        iss_valid = 1'b0;
        #1;
        check("t4_stall_set", {31'd0, stall}, 32'd1);
        wb_req = 2'b01; wb_addr0 = 5'd7; wb_data0 = 32'h77;
        #1;
        check("t4_stall_grant", {31'd0, stall}, 32'd1);
        step();
        wb_req = 2'b00;
        #1;
        check("t4_stall_clr", {31'd0, stall}, 32'd0);
        step();

        // Issue and writeback of r9 in the same cycle: the new producer keeps it busy.
        iss_valid = 1'b1; iss_addr = 5'd9;
        wb_req = 2'b10; wb_addr1 = 5'd9; wb_data1 = 32'h99;
        q_addr_a = 5'd0; q_addr_b = 5'd9;
        step();
        iss_valid = 1'b0; wb_req = 2'b00;
        #1;
        check("t5_stall", {31'd0, stall}, 32'd1);
        check("t5_ls",    {31'd0, L_S}, 32'd1);
        step();
        check("t5_hold",  {31'd0, stall}, 32'd1);

        // Writeback to r0 is acked but never written; r0 never stalls.
        wb_req = 2'b01; wb_addr0 = 5'd0; wb_data0 = 32'h1;
        q_addr_a = 5'd0; q_addr_b = 5'd0;
        #1;
        check("t6_ack",   {30'd0, wb_ack}, 32'd1);
        check("t6_stall", {31'd0, stall}, 32'd0);
        step();
        wb_req = 2'b00;
        check("t6_ls", {31'd0, L_S}, 32'd0);
        step();

        // Randomized traffic with held-until-acked requests and occasional reset.
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_ack = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || last_ack[p]) begin
                    pend[p]   = ($urandom_range(0, 3) != 0);
                    r_addr[p] = 5'($urandom_range(0, 7));
                    r_data[p] = $urandom;
                end
            end
            wb_req    = {pend[1], pend[0]};
            wb_addr0  = r_addr[0]; wb_data0 = r_data[0];
            wb_addr1  = r_addr[1]; wb_data1 = r_data[1];
            rst       = ($urandom_range(0, 99) == 0);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = 5'($urandom_range(0, 7));
            q_addr_a  = 5'($urandom_range(0, 7));
            q_addr_b  = 5'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
